uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 serial receiver driven by a 16x baud enable (ce_16).
//                ser_in is synchronised, each bit is decided near its centre,
//                and good bytes / framing errors are flagged by one-clock
//                pulses. Optional macro UART_RX_MAJORITY_EN switches from a
//                single centre sample (tick 7) to a 2-of-3 vote over ticks
//                6, 7 and 8 (decision at tick 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_16,
    input  logic       ser_in,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] c_DECISION_TICK = 4'd8;
`else
    localparam logic [3:0] c_DECISION_TICK = 4'd7;
`endif
    localparam logic [3:0] c_LAST_TICK = 4'd15;
    localparam logic [2:0] c_LAST_BIT  = 3'd7;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_in_sync;
    logic                   w_bit;
    state_t                 r_state;
    logic [3:0]             r_tick;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [7:0]             r_rx_data;
    logic                   r_new_rx_data;
    logic                   r_frame_err;
    logic                   r_armed;

    // Synchroniser chain for the asynchronous line; resets to the idle level
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ser_in};
        end
    end

    assign w_in_sync = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_samp;

    // Capture the tick-6 and tick-7 samples; the tick-8 sample is live
    always_ff @(posedge clock) begin
        if (reset) begin
            r_samp <= 2'b00;
        end else if (ce_16 && (r_state != ST_IDLE)) begin
            if (r_tick == 4'd6) r_samp[0] <= w_in_sync;
            if (r_tick == 4'd7) r_samp[1] <= w_in_sync;
        end
    end

    assign w_bit = (r_samp[0] & r_samp[1]) |
                   (r_samp[0] & w_in_sync) |
                   (r_samp[1] & w_in_sync);
`else
    assign w_bit = w_in_sync;
`endif

    // Receive state machine, counters, shift register and result pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tick        <= 4'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_rx_data     <= 8'h00;
            r_new_rx_data <= 1'b0;
            r_frame_err   <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_new_rx_data <= 1'b0;
            r_frame_err   <= 1'b0;
            if (ce_16) begin
                case (r_state)
                    ST_IDLE: begin
                        // Arming only while idle keeps a line that stays low
                        // after a bad stop bit (or a break) from starting a
                        // new frame until it has returned high.
                        if (w_in_sync) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state <= ST_START;
                            r_tick  <= 4'd0;
                            r_armed <= 1'b0;
                        end
                    end
                    ST_START: begin
                        r_tick <= r_tick + 4'd1;
                        if ((r_tick == c_DECISION_TICK) && w_bit) begin
                            r_state <= ST_IDLE;
                        end else if (r_tick == c_LAST_TICK) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == c_DECISION_TICK) begin
                            r_shift <= {w_bit, r_shift[7:1]};
                        end
                        if (r_tick == c_LAST_TICK) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == c_LAST_BIT) r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        r_tick <= r_tick + 4'd1;
                        // Leave at mid stop bit so a following start edge is
                        // caught even with no idle gap between frames.
                        if (r_tick == c_DECISION_TICK) begin
                            if (w_bit) begin
                                r_rx_data     <= r_shift;
                                r_new_rx_data <= 1'b1;
                            end else begin
                                r_frame_err   <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign new_rx_data = r_new_rx_data;
    assign frame_err   = r_frame_err;
    assign rx_busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
